// File: rtl/serial_add_sub_nand_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_add_sub_nand_pkg;

  // Control states of the serial engine.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sub_nand_fa.sv
// NAND-only full adder: nine two-input NANDs produce both sum and carry.
module full_adder_nand (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic n1, n2, n3, n4, n5, n6, n7;

  assign n1   = ~(a & b);
  assign n2   = ~(a & n1);
  assign n3   = ~(b & n1);
  assign n4   = ~(n2 & n3);   // a ^ b
  assign n5   = ~(n4 & cin);
  assign n6   = ~(n4 & n5);
  assign n7   = ~(cin & n5);
  assign sum  = ~(n6 & n7);   // a ^ b ^ cin
  assign cout = ~(n1 & n5);   // (a & b) | (cin & (a ^ b))

endmodule

// File: rtl/serial_add_sub_nand.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a
// single NAND full-adder cell. Subtraction is a + ~b + 1.
module serial_add_sub_nand
  import serial_add_sub_nand_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_msb;
  logic             load;

  full_adder_nand u_fa (
    .a   (shift_a_q[0]),
    .b   (shift_b_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  // Next-state logic: operand load, one serial step per RUN cycle, and flag capture.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    load      = 1'b0;
    sum_msb   = '0;
    sum_msb[WIDTH-1] = fa_sum;

    case (state_q)
      ST_IDLE: begin
        if (start) load = 1'b1;
      end
      ST_RUN: begin
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        result_d  = (result_q >> 1) | sum_msb;
        carry_d   = fa_cout;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) load = 1'b1;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new operation takes priority in IDLE and DONE alike (back-to-back).
    if (load) begin
      shift_a_d = a;
      shift_b_d = sub ? ~b : b;
      carry_d   = sub;
      cnt_d     = '0;
      result_d  = '0;
      state_d   = ST_RUN;
    end
  end

  // Status outputs are registered copies of the next state.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State registers with synchronous reset; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
